// File: rtl/bram_trail_pkg.sv
// Shared definitions for the playfield trail writer.
//   ROW_W / ADDR_W : row geometry of the lsb/msb BRAM pair.
//   CELL_*         : 2-bit cell codes, {msb,lsb}.
//   state_t        : writer sequencing states.
package bram_trail_pkg;

  localparam int ROW_W  = 1024;
  localparam int ADDR_W = 10;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_RSVD   = 2'b01;
  localparam logic [1:0] CELL_TRAIL  = 2'b10;
  localparam logic [1:0] CELL_SHADED = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_WIN = 3'd1,
    ST_RADDR    = 3'd2,
    ST_RWAIT    = 3'd3,
    ST_MERGE    = 3'd4,
    ST_WRITE    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/trail_row_merge.sv
// Combinational span merge of one playfield row (lsb and msb planes).
// Ports:
//   rd_lsb, rd_msb  : row as read from the BRAM, bit index = x.
//   xstart, xstop   : inclusive span; xstop is clamped to ROW_W-1.
//   code            : cell code painted into the span.
//   wr_lsb, wr_msb  : merged row; cells outside the span are unchanged.
//   write_en        : span is non-empty and the code is writable.
module trail_row_merge
  import bram_trail_pkg::*;
#(
  parameter int PROTECT_SHADED = 1
) (
  input  logic [0:ROW_W-1] rd_lsb,
  input  logic [0:ROW_W-1] rd_msb,
  input  logic [9:0]       xstart,
  input  logic [9:0]       xstop,
  input  logic [1:0]       code,
  output logic [0:ROW_W-1] wr_lsb,
  output logic [0:ROW_W-1] wr_msb,
  output logic             write_en
);

  localparam logic [10:0] XMAX_C = 11'(ROW_W - 1);
  localparam logic [10:0] XLIM_C = 11'(ROW_W);

  logic [10:0] xs_s;
  logic        empty_s;

  assign xs_s     = ({1'b0, xstop} > XMAX_C) ? XMAX_C : {1'b0, xstop};
  assign empty_s  = ({1'b0, xstart} > xs_s) || ({1'b0, xstart} >= XLIM_C);
  assign write_en = !empty_s && (code != CELL_RSVD);

  for (genvar gx = 0; gx < ROW_W; gx++) begin : g_cell
    logic in_span_s;
    logic keep_s;

    assign in_span_s = (11'(gx) >= {1'b0, xstart}) && (11'(gx) <= xs_s);
    // A trail stroke must not erase territory that is already shaded.
    assign keep_s    = (PROTECT_SHADED != 0) && (code == CELL_TRAIL) &&
                       rd_msb[gx] && rd_lsb[gx];
    assign wr_msb[gx] = (in_span_s && !keep_s) ? code[1] : rd_msb[gx];
    assign wr_lsb[gx] = (in_span_s && !keep_s) ? code[0] : rd_lsb[gx];
  end

endmodule

// File: rtl/bram_trail_writer.sv
// Read-modify-write span painter for the playfield row BRAM (port A).
// Ports:
//   clk_65M, clear_n         : pixel clock, asynchronous active-low reset.
//   req_*                    : one span request (row, inclusive x range, code).
//   wr_window                : BRAM access permitted (vertical blanking).
//   r_addr_*, r_data_*       : row read, READ_LATENCY cycles address-to-data.
//   w_addr, w_data_*, we     : merged row write, one strobe per request.
//   done                     : one-cycle pulse after the write slot.
//   busy                     : high whenever not idle.
module bram_trail_writer
  import bram_trail_pkg::*;
#(
  parameter int READ_LATENCY   = 2,
  parameter int PROTECT_SHADED = 1
) (
  input  logic              clk_65M,
  input  logic              clear_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_row,
  input  logic [9:0]        req_xstart,
  input  logic [9:0]        req_xstop,
  input  logic [1:0]        req_code,
  input  logic              wr_window,
  output logic [ADDR_W-1:0] r_addr_lsb,
  output logic [ADDR_W-1:0] r_addr_msb,
  input  logic [0:ROW_W-1]  r_data_lsb,
  input  logic [0:ROW_W-1]  r_data_msb,
  output logic [ADDR_W-1:0] w_addr,
  output logic [0:ROW_W-1]  w_data_lsb,
  output logic [0:ROW_W-1]  w_data_msb,
  output logic              we,
  output logic              done,
  output logic              busy
);

  localparam logic [1:0] WAIT_LOAD_C = 2'(READ_LATENCY - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] row_r;
  logic [9:0]        xstart_r;
  logic [9:0]        xstop_r;
  logic [1:0]        code_r;
  logic [1:0]        cnt_r;
  logic [0:ROW_W-1]  rd_lsb_r;
  logic [0:ROW_W-1]  rd_msb_r;
  logic [0:ROW_W-1]  mrg_lsb_s;
  logic [0:ROW_W-1]  mrg_msb_s;
  logic              mrg_we_s;

  trail_row_merge #(
    .PROTECT_SHADED(PROTECT_SHADED)
  ) u_merge (
    .rd_lsb  (rd_lsb_r),
    .rd_msb  (rd_msb_r),
    .xstart  (xstart_r),
    .xstop   (xstop_r),
    .code    (code_r),
    .wr_lsb  (mrg_lsb_s),
    .wr_msb  (mrg_msb_s),
    .write_en(mrg_we_s)
  );

  // Request sequencing: accept, wait for the window, read, merge, write, done.
  always_ff @(posedge clk_65M or negedge clear_n) begin
    if (!clear_n) begin
      state_r    <= ST_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      we         <= 1'b0;
      done       <= 1'b0;
      row_r      <= '0;
      xstart_r   <= 10'd0;
      xstop_r    <= 10'd0;
      code_r     <= 2'b00;
      cnt_r      <= 2'd0;
      rd_lsb_r   <= '0;
      rd_msb_r   <= '0;
      r_addr_lsb <= '0;
      r_addr_msb <= '0;
      w_addr     <= '0;
      w_data_lsb <= '0;
      w_data_msb <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            row_r     <= req_row;
            xstart_r  <= req_xstart;
            xstop_r   <= req_xstop;
            code_r    <= req_code;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (wr_window) begin
              r_addr_lsb <= req_row;
              r_addr_msb <= req_row;
              state_r    <= ST_RADDR;
            end else begin
              state_r <= ST_WAIT_WIN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT_WIN: begin
          if (wr_window) begin
            r_addr_lsb <= row_r;
            r_addr_msb <= row_r;
            state_r    <= ST_RADDR;
          end else begin
            state_r <= ST_WAIT_WIN;
          end
        end
        ST_RADDR: begin
          if (!wr_window) begin
            state_r <= ST_WAIT_WIN;
          end else begin
            cnt_r   <= WAIT_LOAD_C;
            state_r <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          // Losing the window here discards the in-flight read entirely.
          if (!wr_window) begin
            state_r <= ST_WAIT_WIN;
          end else if (cnt_r == 2'd0) begin
            rd_lsb_r <= r_data_lsb;
            rd_msb_r <= r_data_msb;
            state_r  <= ST_MERGE;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_MERGE: begin
          // The window is sampled on the edge that enters WRITE, so the
          // strobe is only ever raised while access is still granted.
          if (!wr_window) begin
            state_r <= ST_WAIT_WIN;
          end else begin
            w_addr     <= row_r;
            w_data_lsb <= mrg_lsb_s;
            w_data_msb <= mrg_msb_s;
            we         <= mrg_we_s;
            state_r    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          done    <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_trail_writer.sv
`timescale 1ns/1ps
module tb_bram_trail_writer;
  import bram_trail_pkg::*;

  localparam int RL    = 2;
  localparam int NROWS = 768;

  logic              clk_65M;
  logic              clear_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_row;
  logic [9:0]        req_xstart;
  logic [9:0]        req_xstop;
  logic [1:0]        req_code;
  logic              wr_window;
  logic [ADDR_W-1:0] r_addr_lsb;
  logic [ADDR_W-1:0] r_addr_msb;
  logic [0:ROW_W-1]  r_data_lsb;
  logic [0:ROW_W-1]  r_data_msb;
  logic [ADDR_W-1:0] w_addr;
  logic [0:ROW_W-1]  w_data_lsb;
  logic [0:ROW_W-1]  w_data_msb;
  logic              we;
  logic              done;
  logic              busy;

  bram_trail_writer #(.READ_LATENCY(RL), .PROTECT_SHADED(1)) dut (
    .clk_65M   (clk_65M),
    .clear_n   (clear_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_row   (req_row),
    .req_xstart(req_xstart),
    .req_xstop (req_xstop),
    .req_code  (req_code),
    .wr_window (wr_window),
    .r_addr_lsb(r_addr_lsb),
    .r_addr_msb(r_addr_msb),
    .r_data_lsb(r_data_lsb),
    .r_data_msb(r_data_msb),
    .w_addr    (w_addr),
    .w_data_lsb(w_data_lsb),
    .w_data_msb(w_data_msb),
    .we        (we),
    .done      (done),
    .busy      (busy)
  );

  initial clk_65M = 1'b0;
  always #5 clk_65M = ~clk_65M;

  // BRAM model: pipelined read of RL cycles, write on we, bench poke port.
  logic [0:ROW_W-1] mem_lsb  [0:NROWS-1];
  logic [0:ROW_W-1] mem_msb  [0:NROWS-1];
  logic [0:ROW_W-1] pipe_lsb [0:RL-1];
  logic [0:ROW_W-1] pipe_msb [0:RL-1];
  logic             poke_en = 1'b0;
  logic [9:0]       poke_row;
  logic [0:ROW_W-1] poke_lsb;
  logic [0:ROW_W-1] poke_msb;

  always @(posedge clk_65M) begin
    pipe_lsb[0] <= (r_addr_lsb < 10'(NROWS)) ? mem_lsb[r_addr_lsb] : '0;
    pipe_msb[0] <= (r_addr_msb < 10'(NROWS)) ? mem_msb[r_addr_msb] : '0;
    for (int i = 1; i < RL; i++) begin
      pipe_lsb[i] <= pipe_lsb[i-1];
      pipe_msb[i] <= pipe_msb[i-1];
    end
    if (we && (w_addr < 10'(NROWS))) begin
      mem_lsb[w_addr] <= w_data_lsb;
      mem_msb[w_addr] <= w_data_msb;
    end
    if (poke_en) begin
      mem_lsb[poke_row] <= poke_lsb;
      mem_msb[poke_row] <= poke_msb;
    end
  end
  assign r_data_lsb = pipe_lsb[RL-1];
  assign r_data_msb = pipe_msb[RL-1];

  typedef struct {
    logic [9:0]       row;
    logic [0:ROW_W-1] lsb;
    logic [0:ROW_W-1] msb;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_count = 0;
  int done_count = 0;
  int we_cyc = -1;
  int done_cyc = -1;

  always @(posedge clk_65M) cyc <= cyc + 1;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk_65M) begin
    sb_t e;
    if (done) begin
      done_count = done_count + 1;
      done_cyc = cyc;
    end
    if (we) begin
      we_count = we_count + 1;
      we_cyc = cyc;
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_we row=%0d (no write was expected)", w_addr);
      end else begin
        e = sb.pop_front();
        if (w_addr !== e.row || w_data_lsb !== e.lsb || w_data_msb !== e.msb) begin
          failures = failures + 1;
          $display("FAIL write_data row got=%0d exp=%0d lsb_bits_wrong=%0d msb_bits_wrong=%0d",
                   w_addr, e.row, $countones(w_data_lsb ^ e.lsb), $countones(w_data_msb ^ e.msb));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: paint cells xs..min(xe,ROW_W-1); TRAIL leaves SHADED cells alone.
  function automatic bit model_row(input logic [0:ROW_W-1] il, input logic [0:ROW_W-1] im,
                                   input int xs, input int xe, input logic [1:0] code,
                                   output logic [0:ROW_W-1] ol, output logic [0:ROW_W-1] om);
    int hi;
    ol = il;
    om = im;
    hi = (xe > ROW_W - 1) ? ROW_W - 1 : xe;
    if (code == 2'b01 || xs > hi || xs >= ROW_W) return 1'b0;
    for (int x = xs; x <= hi; x++) begin
      if (!(code == CELL_TRAIL && im[x] === 1'b1 && il[x] === 1'b1)) begin
        om[x] = code[1];
        ol[x] = code[0];
      end
    end
    return 1'b1;
  endfunction

  function automatic bit push_expect(input logic [9:0] row, input logic [9:0] xs,
                                     input logic [9:0] xe, input logic [1:0] code);
    sb_t e;
    bit wr;
    wr = model_row(mem_lsb[row], mem_msb[row], int'(xs), int'(xe), code, e.lsb, e.msb);
    e.row = row;
    if (wr) sb.push_back(e);
    return wr;
  endfunction

  task automatic poke(input logic [9:0] row, input logic [0:ROW_W-1] l, input logic [0:ROW_W-1] m);
    @(negedge clk_65M);
    poke_row = row;
    poke_lsb = l;
    poke_msb = m;
    poke_en  = 1'b1;
    @(negedge clk_65M);
    poke_en  = 1'b0;
  endtask

  // kind 0: all empty, 1: empty with SHADED at x 100..104, 2: random.
  task automatic fill_row(input logic [9:0] row, input int kind);
    logic [0:ROW_W-1] l;
    logic [0:ROW_W-1] m;
    l = '0;
    m = '0;
    if (kind == 1) begin
      for (int x = 100; x <= 104; x++) begin
        l[x] = 1'b1;
        m[x] = 1'b1;
      end
    end else if (kind == 2) begin
      for (int i = 0; i < ROW_W / 32; i++) begin
        l[i*32 +: 32] = $urandom();
        m[i*32 +: 32] = $urandom();
      end
    end
    poke(row, l, m);
  endtask

  task automatic start_req(input logic [9:0] row, input logic [9:0] xs,
                           input logic [9:0] xe, input logic [1:0] code);
    req_row    = row;
    req_xstart = xs;
    req_xstop  = xe;
    req_code   = code;
    req_valid  = 1'b1;
  endtask

  // Returns the cycle number T of the accepting edge.
  task automatic wait_accept(output int t);
    bit ok;
    ok = 1'b0;
    t = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk_65M);
      if (req_ready) begin
        t = cyc;
        ok = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL accept_timeout got=no_handshake exp=handshake");
    end
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_65M);
      #1;
      if (done_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL done_timeout got=%0d exp=%0d", done_count, target);
    end
  endtask

  typedef struct {
    logic [9:0] row;
    logic [9:0] xs;
    logic [9:0] xe;
    logic [1:0] code;
    int         fill;
    bit         exp_we;
  } vec_t;

  vec_t vt[9];

  initial begin
    int t, t2, we0, d0;
    bit wr;

    vt[0] = '{10'd400, 10'd600,  10'd610,  CELL_TRAIL,  0, 1'b1};
    vt[1] = '{10'd50,  10'd98,   10'd106,  CELL_TRAIL,  1, 1'b1};
    vt[2] = '{10'd60,  10'd1020, 10'd1023, CELL_SHADED, 2, 1'b1};
    vt[3] = '{10'd61,  10'd700,  10'd690,  CELL_TRAIL,  2, 1'b0};
    vt[4] = '{10'd62,  10'd0,    10'd0,    CELL_EMPTY,  2, 1'b1};
    vt[5] = '{10'd63,  10'd5,    10'd900,  CELL_TRAIL,  2, 1'b1};
    vt[6] = '{10'd64,  10'd10,   10'd20,   CELL_RSVD,   2, 1'b0};
    vt[7] = '{10'd65,  10'd0,    10'd1023, CELL_SHADED, 2, 1'b1};
    vt[8] = '{10'd767, 10'd1023, 10'd1023, CELL_EMPTY,  2, 1'b1};

    clear_n    = 1'b0;
    req_valid  = 1'b0;
    req_row    = '0;
    req_xstart = 10'd0;
    req_xstop  = 10'd0;
    req_code   = 2'b00;
    wr_window  = 1'b0;

    repeat (3) @(posedge clk_65M);
    @(negedge clk_65M);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_we", 32'(we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_r_addr", 32'({r_addr_lsb, r_addr_msb}), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_w_data_zero", 32'((w_data_lsb | w_data_msb) == '0), 32'd1);
    clear_n   = 1'b1;
    wr_window = 1'b1;

    // Table of single requests with the window held open.
    for (int i = 0; i < 9; i++) begin
      fill_row(vt[i].row, vt[i].fill);
      wr = push_expect(vt[i].row, vt[i].xs, vt[i].xe, vt[i].code);
      we0 = we_count;
      d0  = done_count;
      @(negedge clk_65M);
      start_req(vt[i].row, vt[i].xs, vt[i].xe, vt[i].code);
      wait_accept(t);
      #1 req_valid = 1'b0;
      wait_done(d0 + 1);
      check($sformatf("vec%0d_we_count", i), 32'(we_count - we0), 32'(vt[i].exp_we));
      check($sformatf("vec%0d_done_cycle", i), 32'(done_cyc - t), 32'd6);
      if (vt[i].exp_we) check($sformatf("vec%0d_we_cycle", i), 32'(we_cyc - t), 32'd5);
      check($sformatf("vec%0d_ready_in_done", i), 32'(req_ready), 32'd0);
      @(negedge clk_65M);
      check($sformatf("vec%0d_ready_after", i), 32'(req_ready), 32'd1);
      check($sformatf("vec%0d_single_done", i), 32'(done_count - d0), 32'd1);
    end

    // Direct spot checks on the resulting rows.
    check("basic_msb_span", 32'(mem_msb[400][600 +: 11]), 32'h7FF);
    check("basic_lsb_clear", 32'(mem_lsb[400] == '0), 32'd1);
    check("basic_msb_outside", 32'({mem_msb[400][599], mem_msb[400][611]}), 32'd0);
    check("protect_msb", 32'(mem_msb[50][98 +: 9]), 32'h1FF);
    check("protect_lsb", 32'(mem_lsb[50][98 +: 9]), 32'b001111100);
    check("clamp_top_cells", 32'({mem_msb[60][1020 +: 4], mem_lsb[60][1020 +: 4]}), 32'hFF);

    // Window drop during RWAIT, return 20 cycles later with new row contents.
    fill_row(10'd70, 2);
    we0 = we_count;
    d0  = done_count;
    @(negedge clk_65M);
    start_req(10'd70, 10'd10, 10'd20, CELL_TRAIL);
    wait_accept(t);
    #1 req_valid = 1'b0;
    @(posedge clk_65M);
    #1 wr_window = 1'b0;
    repeat (20) @(posedge clk_65M);
    fill_row(10'd70, 2);
    wr = push_expect(10'd70, 10'd10, 10'd20, CELL_TRAIL);
    check("drop_busy_waiting", 32'(busy), 32'd1);
    check("drop_no_we_yet", 32'(we_count - we0), 32'd0);
    @(negedge clk_65M);
    wr_window = 1'b1;
    wait_done(d0 + 1);
    check("drop_we_once", 32'(we_count - we0), 32'd1);
    check("drop_done_once", 32'(done_count - d0), 32'd1);

    // Back-to-back: second request held valid while the first runs.
    fill_row(10'd80, 2);
    fill_row(10'd81, 2);
    wr = push_expect(10'd80, 10'd100, 10'd200, CELL_SHADED);
    wr = push_expect(10'd81, 10'd300, 10'd400, CELL_EMPTY);
    we0 = we_count;
    d0  = done_count;
    @(negedge clk_65M);
    start_req(10'd80, 10'd100, 10'd200, CELL_SHADED);
    wait_accept(t);
    #1 start_req(10'd81, 10'd300, 10'd400, CELL_EMPTY);
    wait_accept(t2);
    #1 req_valid = 1'b0;
    check("b2b_accept_gap", 32'(t2 - t), 32'd7);
    wait_done(d0 + 2);
    check("b2b_we_count", 32'(we_count - we0), 32'd2);

    // Reset asserted while in MERGE abandons the request.
    fill_row(10'd90, 2);
    we0 = we_count;
    d0  = done_count;
    @(negedge clk_65M);
    start_req(10'd90, 10'd0, 10'd50, CELL_TRAIL);
    wait_accept(t);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk_65M);
    #2 clear_n = 1'b0;
    #1;
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_we", 32'(we), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk_65M);
    clear_n = 1'b1;
    repeat (15) @(negedge clk_65M);
    check("rstmid_no_write", 32'(we_count - we0), 32'd0);
    check("rstmid_no_done", 32'(done_count - d0), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
